// File: rtl/axi_bridge_pkg.sv
// Shared constants, write-FSM state type and sizing helper for the N-port
// SRAM-like to AXI3 bridge.
package axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_bridge_nport_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer that
// moves to winner+1 whenever advance is asserted with a live grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  int            win;
  int            idx;

  always_comb begin
    grant = '0;
    win   = 0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if ((grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && (grant != '0)) begin
      ptr <= (win == N - 1) ? '0 : PW'(win + 1);
    end
  end

endmodule

// File: rtl/axi_bridge_nport.sv
// NUM_PORTS SRAM-like request ports merged onto one AXI3 master with RR
// arbitration, per-port outstanding reads and RAW protection.
// Optional error reporting (p_err, err_seen) enabled by AXI_BRIDGE_ERR_EN.
// Handshake: p_addr_ok is a same-cycle accept of p_req; p_data_ok is a
// one-cycle pulse; AXI channels use standard valid/ready (transfer when both high).
module axi_bridge_nport
  import axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int RD_OUTSTANDING = 2,
  parameter int ID_W           = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      p_req,
  input  logic [NUM_PORTS-1:0]      p_wr,
  input  logic [2*NUM_PORTS-1:0]    p_size,
  input  logic [4*NUM_PORTS-1:0]    p_wstrb,
  input  logic [32*NUM_PORTS-1:0]   p_addr,
  input  logic [32*NUM_PORTS-1:0]   p_wdata,
  output logic [NUM_PORTS-1:0]      p_addr_ok,
  output logic [NUM_PORTS-1:0]      p_data_ok,
  output logic [32*NUM_PORTS-1:0]   p_rdata,
  output logic [ID_W-1:0]           arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_W-1:0]           rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [ID_W-1:0]           awid,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic [1:0]                awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ID_W-1:0]           wid,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [ID_W-1:0]           bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
`ifdef AXI_BRIDGE_ERR_EN
  output logic [NUM_PORTS-1:0]      p_err,
  output logic                      err_seen,
`endif
  output logic [1:0]                w_state_dbg
);

  localparam int             CW     = cnt_w(RD_OUTSTANDING);
  localparam logic [CW-1:0]  RD_MAX = CW'(RD_OUTSTANDING);

  logic [NUM_PORTS-1:0] rd_elig, rd_grant, wr_req, wr_grant, rd_ok, b_ok, raw;
  logic                 rd_adv, wr_adv, ar_free;
  logic [CW-1:0]        rd_cnt [NUM_PORTS];
  int                   rd_win, wr_win;

  w_state_t             w_state;
  logic [ID_W-1:0]      w_id;
  logic [31:0]          w_addr, w_data;
  logic [3:0]           w_strb;
  logic [1:0]           w_size;

  always_comb begin
    ar_free = ~arvalid | arready;
    raw     = '0;
    rd_elig = '0;
    wr_req  = '0;
    rd_ok   = '0;
    b_ok    = '0;
    p_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // A read to the word held by the in-flight write must wait for B.
      raw[i]     = (w_state != W_IDLE) && (p_addr[i*32+2 +: 30] == w_addr[31:2]);
      rd_elig[i] = ~rst & p_req[i] & ~p_wr[i] & (rd_cnt[i] < RD_MAX) & ~raw[i] & ar_free;
      wr_req[i]  = ~rst & p_req[i] & p_wr[i] & (w_state == W_IDLE);
      rd_ok[i]   = ~rst & rvalid & (rid == ID_W'(i));
      b_ok[i]    = ~rst & bvalid & (w_state == W_RESP) & (bid == ID_W'(i));
      if (rd_ok[i]) p_rdata[i*32 +: 32] = rdata;
    end
    rd_win = 0;
    wr_win = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_grant[i]) rd_win = i;
      if (wr_grant[i]) wr_win = i;
    end
  end

  assign rd_adv    = |rd_elig;
  assign wr_adv    = |wr_req;
  assign p_addr_ok = rd_grant | wr_grant;
  assign p_data_ok = rd_ok | b_ok;

  rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
    .clk(clk), .rst(rst), .req(rd_elig), .advance(rd_adv), .grant(rd_grant)
  );

  rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
    .clk(clk), .rst(rst), .req(wr_req), .advance(wr_adv), .grant(wr_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
    end else if (rd_adv) begin
      arvalid <= 1'b1;
      arid    <= ID_W'(rd_win);
      araddr  <= p_addr[rd_win*32 +: 32];
      arsize  <= {1'b0, p_size[rd_win*2 +: 2]};
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // Accept and return on one port in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) rd_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        rd_cnt[i] <= rd_cnt[i] + CW'(rd_grant[i]) - CW'(rd_ok[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      w_id    <= '0;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_size  <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (wr_adv) begin
          w_id    <= ID_W'(wr_win);
          w_addr  <= p_addr[wr_win*32 +: 32];
          w_data  <= p_wdata[wr_win*32 +: 32];
          w_strb  <= p_wstrb[wr_win*4 +: 4];
          w_size  <= p_size[wr_win*2 +: 2];
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          w_state <= W_SEND;
        end
        W_SEND: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((~awvalid | awready) & (~wvalid | wready)) w_state <= W_RESP;
        end
        W_RESP: if (bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign awid    = w_id;
  assign awaddr  = w_addr;
  assign awsize  = {1'b0, w_size};
  assign wid     = w_id;
  assign wdata   = w_data;
  assign wstrb   = w_strb;
  assign wlast   = 1'b1;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign w_state_dbg = w_state;

`ifdef AXI_BRIDGE_ERR_EN
  assign p_err = (rd_ok & {NUM_PORTS{rresp != RESP_OKAY}})
               | (b_ok  & {NUM_PORTS{bresp != RESP_OKAY}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_seen <= 1'b0;
    else if (|p_err) err_seen <= 1'b1;
  end

  logic unused_in;
  assign unused_in = rlast;
`else
  logic unused_in;
  assign unused_in = ^{rresp, bresp, rlast};
`endif

endmodule

// File: tb/tb_axi_bridge_nport.sv
// Directed bench for axi_bridge_nport (2 ports, 2 outstanding reads).
module tb_axi_bridge_nport;

  logic        clk, rst;
  logic [1:0]  p_req, p_wr, p_addr_ok, p_data_ok;
  logic [3:0]  p_size;
  logic [7:0]  p_wstrb;
  logic [63:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp, w_state_dbg;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef AXI_BRIDGE_ERR_EN
  logic [1:0]  p_err;
  logic        err_seen;
`endif

  int errors = 0;
  int checks = 0;

  axi_bridge_nport #(.NUM_PORTS(2), .RD_OUTSTANDING(2), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .p_req(p_req), .p_wr(p_wr), .p_size(p_size),
    .p_wstrb(p_wstrb), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_addr_ok(p_addr_ok), .p_data_ok(p_data_ok), .p_rdata(p_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef AXI_BRIDGE_ERR_EN
    .p_err(p_err), .err_seen(err_seen),
`endif
    .w_state_dbg(w_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; p_req = '0; p_wr = '0; p_size = '0; p_wstrb = '0;
    p_addr = '0; p_wdata = '0; arready = 0; rid = '0; rdata = '0; rresp = '0;
    rlast = 1'b1; rvalid = 0; awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    step(); #4;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%0h exp=0", arvalid); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got=%0h exp=0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%0h exp=0", wvalid); end
    checks++; if (p_addr_ok !== 2'b00) begin errors++; $display("FAIL reset_addr_ok got=%0h exp=0", p_addr_ok); end
    checks++; if (p_data_ok !== 2'b00) begin errors++; $display("FAIL reset_data_ok got=%0h exp=0", p_data_ok); end
    checks++; if (p_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", p_rdata); end
    checks++; if (w_state_dbg !== 2'd0) begin errors++; $display("FAIL reset_wstate got=%0d exp=0", w_state_dbg); end
    checks++; if ({arlen, awlen, arburst, awburst} !== {8'd0, 8'd0, 2'b01, 2'b01}) begin errors++; $display("FAIL const_len_burst got=%0h exp=%0h", {arlen, awlen, arburst, awburst}, {8'd0, 8'd0, 2'b01, 2'b01}); end
    checks++; if ({arlock, arcache, arprot, awlock, awcache, awprot} !== 18'd0) begin errors++; $display("FAIL const_lock_cache_prot got=%0h exp=0", {arlock, arcache, arprot, awlock, awcache, awprot}); end
    checks++; if ({wlast, rready, bready} !== 3'b111) begin errors++; $display("FAIL const_last_ready got=%0b exp=111", {wlast, rready, bready}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    arready = 1'b1;
    p_req = 2'b10; p_wr = 2'b00; p_addr[63:32] = 32'h1C000004; p_size[3:2] = 2'd2;
    #4;
    checks++; if (p_addr_ok !== 2'b10) begin errors++; $display("FAIL single_addr_ok got=%0b exp=10", p_addr_ok); end
    step();
    p_req = 2'b00;
    #4;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got=%0h exp=1", arvalid); end
    checks++; if (arid !== 4'd1) begin errors++; $display("FAIL single_arid got=%0h exp=1", arid); end
    checks++; if (araddr !== 32'h1C000004) begin errors++; $display("FAIL single_araddr got=%0h exp=1c000004", araddr); end
    checks++; if (arsize !== 3'd2) begin errors++; $display("FAIL single_arsize got=%0h exp=2", arsize); end
    step(); #4;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_ar_drop got=%0h exp=0", arvalid); end
    step();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEADBEEF;
    #4;
    checks++; if (p_data_ok !== 2'b10) begin errors++; $display("FAIL single_data_ok got=%0b exp=10", p_data_ok); end
    checks++; if (p_rdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%0h exp=deadbeef", p_rdata[63:32]); end
    checks++; if (p_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL single_rdata_other got=%0h exp=0", p_rdata[31:0]); end
    step();
    rvalid = 1'b0;
    #4;
    checks++; if (p_data_ok !== 2'b00) begin errors++; $display("FAIL single_data_ok_clear got=%0b exp=00", p_data_ok); end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_ok;
    logic [3:0] exp_id;
    arready = 1'b1;
    p_req = 2'b11; p_wr = 2'b00;
    p_addr = {32'h00002000, 32'h00001000}; p_size = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_ok = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_id = (k % 2 == 0) ? 4'd0 : 4'd1;
      #4;
      checks++; if (p_addr_ok !== exp_ok) begin errors++; $display("FAIL contention_grant%0d got=%0b exp=%0b", k, p_addr_ok, exp_ok); end
      step();
      checks++; if (arid !== exp_id) begin errors++; $display("FAIL contention_arid%0d got=%0h exp=%0h", k, arid, exp_id); end
    end
    p_req = 2'b00;
    rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rid = (k < 2) ? 4'd0 : 4'd1;
      exp_ok = (k < 2) ? 2'b01 : 2'b10;
      #4;
      checks++; if (p_data_ok !== exp_ok) begin errors++; $display("FAIL contention_ret%0d got=%0b exp=%0b", k, p_data_ok, exp_ok); end
      step();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_outstanding();
    logic [1:0] exp_ok [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    arready = 1'b1;
    p_req = 2'b01; p_wr = 2'b00; p_addr[31:0] = 32'h00003000;
    for (int k = 0; k < 5; k++) begin
      rvalid = (k == 3); rid = 4'd0;
      #4;
      checks++; if (p_addr_ok !== exp_ok[k]) begin errors++; $display("FAIL outstanding_ok%0d got=%0b exp=%0b", k, p_addr_ok, exp_ok[k]); end
      if (k == 3) begin
        checks++; if (p_data_ok !== 2'b01) begin errors++; $display("FAIL outstanding_ret got=%0b exp=01", p_data_ok); end
      end
      step();
    end
    p_req = 2'b00;
    rvalid = 1'b1; rid = 4'd2;
    #4;
    checks++; if (p_data_ok !== 2'b00) begin errors++; $display("FAIL bad_rid_dropped got=%0b exp=00", p_data_ok); end
    step();
    rid = 4'd0;
    step(); step();
    rvalid = 1'b0;
  endtask

  task automatic test_write_split();
    p_req = 2'b10; p_wr = 2'b10; p_addr[63:32] = 32'h800000A0;
    p_wdata[63:32] = 32'h12345678; p_wstrb[7:4] = 4'h3; p_size[3:2] = 2'd1;
    #4;
    checks++; if (p_addr_ok !== 2'b10) begin errors++; $display("FAIL write_addr_ok got=%0b exp=10", p_addr_ok); end
    step();
    p_req = 2'b00; p_wr = 2'b00; awready = 1'b1;
    #4;
    checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL write_valids_c1 got=%0b exp=11", {awvalid, wvalid}); end
    checks++; if (awaddr !== 32'h800000A0) begin errors++; $display("FAIL write_awaddr got=%0h exp=800000a0", awaddr); end
    checks++; if ({awid, wid} !== 8'h11) begin errors++; $display("FAIL write_ids got=%0h exp=11", {awid, wid}); end
    checks++; if (wdata !== 32'h12345678) begin errors++; $display("FAIL write_wdata got=%0h exp=12345678", wdata); end
    checks++; if ({wstrb, awsize} !== {4'h3, 3'd1}) begin errors++; $display("FAIL write_strb_size got=%0h exp=%0h", {wstrb, awsize}, {4'h3, 3'd1}); end
    checks++; if (w_state_dbg !== 2'd1) begin errors++; $display("FAIL write_state_send got=%0d exp=1", w_state_dbg); end
    step();
    awready = 1'b0;
    #4;
    checks++; if ({awvalid, wvalid} !== 2'b01) begin errors++; $display("FAIL write_valids_c2 got=%0b exp=01", {awvalid, wvalid}); end
    step();
    wready = 1'b1;
    #4;
    checks++; if ({awvalid, wvalid, w_state_dbg} !== 4'b0101) begin errors++; $display("FAIL write_c3 got=%0b exp=0101", {awvalid, wvalid, w_state_dbg}); end
    step();
    wready = 1'b0; bvalid = 1'b1; bid = 4'd1;
    #4;
    checks++; if ({wvalid, w_state_dbg} !== 3'b010) begin errors++; $display("FAIL write_resp_state got=%0b exp=010", {wvalid, w_state_dbg}); end
    checks++; if (p_data_ok !== 2'b10) begin errors++; $display("FAIL write_bresp_ok got=%0b exp=10", p_data_ok); end
    step();
    bvalid = 1'b0;
    #4;
    checks++; if ({p_data_ok, w_state_dbg} !== 4'b0000) begin errors++; $display("FAIL write_done got=%0b exp=0000", {p_data_ok, w_state_dbg}); end
    step();
  endtask

  task automatic test_raw();
    arready = 1'b1;
    p_req = 2'b01; p_wr = 2'b01; p_addr[31:0] = 32'h00000100;
    p_wdata[31:0] = 32'hCAFEF00D; p_wstrb[3:0] = 4'hF; p_size[1:0] = 2'd2;
    #4;
    checks++; if (p_addr_ok !== 2'b01) begin errors++; $display("FAIL raw_write_ok got=%0b exp=01", p_addr_ok); end
    step();
    p_req = 2'b10; p_wr = 2'b00; p_addr[63:32] = 32'h00000100; p_size[3:2] = 2'd2;
    awready = 1'b1; wready = 1'b1;
    #4;
    checks++; if (p_addr_ok !== 2'b00) begin errors++; $display("FAIL raw_stall_send got=%0b exp=00", p_addr_ok); end
    step();
    awready = 1'b0; wready = 1'b0; p_addr[63:32] = 32'h00000104;
    #4;
    checks++; if (p_addr_ok !== 2'b10) begin errors++; $display("FAIL raw_other_word_ok got=%0b exp=10", p_addr_ok); end
    step();
    checks++; if (araddr !== 32'h00000104) begin errors++; $display("FAIL raw_araddr104 got=%0h exp=104", araddr); end
    p_addr[63:32] = 32'h00000100; bvalid = 1'b1; bid = 4'd0;
    #4;
    checks++; if (p_addr_ok !== 2'b00) begin errors++; $display("FAIL raw_stall_resp got=%0b exp=00", p_addr_ok); end
    checks++; if (p_data_ok !== 2'b01) begin errors++; $display("FAIL raw_bresp_ok got=%0b exp=01", p_data_ok); end
    step();
    bvalid = 1'b0;
    #4;
    checks++; if (p_addr_ok !== 2'b10) begin errors++; $display("FAIL raw_release got=%0b exp=10", p_addr_ok); end
    step();
    p_req = 2'b00;
    checks++; if (araddr !== 32'h00000100) begin errors++; $display("FAIL raw_araddr100 got=%0h exp=100", araddr); end
    rvalid = 1'b1; rid = 4'd1;
    step(); step();
    rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    arready = 1'b1;
    p_req = 2'b11; p_wr = 2'b10;
    p_addr = {32'h00000300, 32'h00000200}; p_size = 4'b1010;
    p_wdata[63:32] = 32'h0BADF00D; p_wstrb[7:4] = 4'hF;
    #4;
    checks++; if (p_addr_ok !== 2'b11) begin errors++; $display("FAIL b2b_both_ok got=%0b exp=11", p_addr_ok); end
    step();
    p_req = 2'b00; p_wr = 2'b00; awready = 1'b1; wready = 1'b1;
    checks++; if ({araddr, awaddr} !== {32'h200, 32'h300}) begin errors++; $display("FAIL b2b_addrs got=%0h exp=%0h", {araddr, awaddr}, {32'h200, 32'h300}); end
    step();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bid = 4'd1; rvalid = 1'b1; rid = 4'd0; rdata = 32'h5A5A5A5A;
    #4;
    checks++; if (p_data_ok !== 2'b11) begin errors++; $display("FAIL b2b_data_ok got=%0b exp=11", p_data_ok); end
    checks++; if (p_rdata !== 64'h000000005A5A5A5A) begin errors++; $display("FAIL b2b_rdata got=%0h exp=5a5a5a5a", p_rdata); end
    step();
    bvalid = 1'b0; rvalid = 1'b0;
    #4;
    checks++; if (w_state_dbg !== 2'd0) begin errors++; $display("FAIL b2b_state got=%0d exp=0", w_state_dbg); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_ok [3] = '{2'b01, 2'b01, 2'b00};
    arready = 1'b1;
    p_req = 2'b01; p_wr = 2'b00; p_addr[31:0] = 32'h00000400;
    step(); step();
    arready = 1'b0;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_arvalid got=%0h exp=1", arvalid); end
    rst = 1'b1;
    #4;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL mid_arvalid got=%0h exp=0", arvalid); end
    checks++; if (p_addr_ok !== 2'b00) begin errors++; $display("FAIL mid_addr_ok got=%0b exp=00", p_addr_ok); end
    step();
    rst = 1'b0; arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      checks++; if (p_addr_ok !== exp_ok[k]) begin errors++; $display("FAIL mid_after_ok%0d got=%0b exp=%0b", k, p_addr_ok, exp_ok[k]); end
      step();
    end
    p_req = 2'b00;
    rvalid = 1'b1; rid = 4'd0;
    step(); step();
    rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_outstanding();
    test_write_split();
    test_raw();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
